// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

    localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_core_ha_cell.sv
// Half-adder cell; two of these plus an OR form the serial full adder.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial W-bit adder: LSB-first through one full adder, carry kept in a flop.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (A-B in two's complement).
module serial_adder_core
    import serial_adder_pkg::*;
#(
    parameter int W = SA_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    sa_state_e     state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic ha0_s, ha0_c, ha1_c;
    logic fa_s, fa_c;
    logic op_sub;
    logic last_bit;
    logic unused_acc_lsb;

`ifdef SERIAL_ADDER_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    ha_cell u_ha0 (.x(sa_q[0]), .y(sb_q[0]), .s(ha0_s), .c(ha0_c));
    ha_cell u_ha1 (.x(ha0_s),   .y(carry_q), .s(fa_s),  .c(ha1_c));
    assign fa_c = ha0_c | ha1_c;

    assign last_bit       = (cnt_q == CW'(W - 1));
    // The accumulator LSB falls off the end of the shift and is never consumed.
    assign unused_acc_lsb = acc_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (start) state_d = SHIFT;
                SHIFT:   if (last_bit) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_d    = a;
                        // Subtraction: invert B and seed the carry with the +1.
                        sb_d    = op_sub ? ~b : b;
                        carry_d = op_sub;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    carry_d = fa_c;
                    acc_d   = {fa_s, acc_q[W-1:1]};
                    sa_d    = {1'b0, sa_q[W-1:1]};
                    sb_d    = {1'b0, sb_q[W-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_d  = {fa_s, acc_q[W-1:1]};
                        cout_d = fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_core.sv
// Scoreboard bench for serial_adder_core: randomized operands vs. an arithmetic model.
module tb_serial_adder_core;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena   = 1'b1;
    logic         start = 1'b0;
    logic         sub_i = 1'b0;
    logic [W-1:0] a_i   = '0;
    logic [W-1:0] b_i   = '0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    serial_adder_core #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_i),
`endif
        .a     (a_i),
        .b     (b_i),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t        e;
        int unsigned xa;
        int unsigned ya;
        xa = x;
        ya = y;
        if (s) begin
            e.s = W'(xa - ya);
            e.c = (xa >= ya);
        end else begin
            e.s = W'(xa + ya);
            e.c = ((xa + ya) >= (32'd1 << W));
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result sum=0x%02h cout=%0d (model sum=0x%02h cout=%0d)", sum, cout, e.s, e.c);
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int stall_at);
        exp_t e;
        int   i;
        int   busy_n;
        int   extra;
        extra = (stall_at > 0) ? 3 : 0;
        @(negedge clk);
        a_i   = x;
        b_i   = y;
        sub_i = s;
        start = 1'b1;
        e     = model(x, y, s);
        exp_q.push_back(e);
        $display("issue a=0x%02h b=0x%02h sub=%0d stall_at=%0d", x, y, s, stall_at);
        @(negedge clk);
        start = 1'b0;
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        sub_i = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("sum_hold", {23'd0, cout, sum}, {23'd0, prev_cout, prev_sum});
        i      = 0;
        busy_n = 0;
        while (!done && i < 60) begin
            if (busy) busy_n++;
            if (stall_at > 0 && i == stall_at) ena = 1'b0;
            if (stall_at > 0 && i == stall_at + 3) ena = 1'b1;
            @(negedge clk);
            i++;
        end
        ena = 1'b1;
        check("done_latency", 32'(i), 32'(W + extra));
        check("busy_cycles", 32'(busy_n), 32'(W + extra));
        check("busy_low_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        prev_sum  = e.s;
        prev_cout = e.c;
    endtask

    task automatic held_start_test();
        int i;
        int j;
        @(negedge clk);
        a_i   = 8'h01;
        b_i   = 8'h02;
        sub_i = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        $display("issue held start a=0x01 b=0x02 then a=0x80 b=0x80");
        i = 0;
        while (!done && i < 60) begin
            @(negedge clk);
            i++;
            if (i == 3) begin
                a_i = 8'h80;
                b_i = 8'h80;
                exp_q.push_back(model(8'h80, 8'h80, 1'b0));
            end
        end
        check("held_first_latency", 32'(i), 32'(W + 1));
        j = 0;
        do begin
            @(negedge clk);
            j++;
        end while (!done && j < 60);
        check("held_throughput", 32'(j), 32'(W + 2));
        start = 1'b0;
        @(negedge clk);
        prev_sum  = 8'h00;
        prev_cout = 1'b1;
    endtask

    task automatic reset_abort_test();
        int seen;
        @(negedge clk);
        a_i   = 8'h5A;
        b_i   = 8'h3C;
        sub_i = 1'b0;
        start = 1'b1;
        $display("issue a=0x5a b=0x3c, aborted by reset at bit 4");
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic s_r;
        int   st;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'h00, 8'h00, 1'b0, 0);
        held_start_test();
        do_op(8'h5A, 8'h3C, 1'b0, 3);
        reset_abort_test();
        do_op(8'h5A, 8'h3C, 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 0);
        do_op(8'h01, 8'h02, 1'b1, 0);
`endif
        for (int n = 0; n < 20; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
            s_r = 1'($urandom);
`else
            s_r = 1'b0;
`endif
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 2)) : 0;
            do_op(W'($urandom), W'($urandom), s_r, st);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
